// File: rtl/edge_region_tracker.sv
// rtl/edge_region_tracker.sv - grid edge-density tracker with EMA smoothing and hysteresis
module edge_region_tracker #(
    parameter int WIDTH        = 640,
    parameter int HEIGHT       = 480,
    parameter int NUM_COLS     = 18,
    parameter int NUM_ROWS     = 2,
    parameter int PIX_W        = 12,
    parameter int COUNT_W      = 16,
    parameter int EDGE_THRESH  = 0,
    parameter int SMOOTH_SHIFT = 1,
    parameter int HYSTERESIS   = 60,
    parameter int N            = NUM_COLS * NUM_ROWS,
    parameter int RW           = (N > 1) ? $clog2(N) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               vga_ready,
    input  logic [PIX_W-1:0]   filtered_video,
    input  logic [9:0]         x_count,
    input  logic [8:0]         y_count,
    output logic [NUM_COLS-1:0] col_leds,
    output logic [NUM_ROWS-1:0] row_leds,
    output logic [RW-1:0]      best_region,
    output logic [COUNT_W-1:0] best_count,
    output logic               result_valid,
    output logic               busy,
    output logic               frame_overrun
);
    localparam int SEC_W = WIDTH / NUM_COLS;
    localparam int SEC_H = HEIGHT / NUM_ROWS;
    localparam logic [COUNT_W-1:0] CMAX = '1;

    typedef enum logic [1:0] {ACCUM, SMOOTH, SCAN, DECIDE} state_t;
    state_t state, state_next;

    logic [COUNT_W-1:0] live [N];
    logic [COUNT_W-1:0] live_inc [N];
    logic [COUNT_W-1:0] snap [N];
    logic [COUNT_W-1:0] smooth [N];

    int          pix_col, pix_row;
    logic [RW-1:0] pix_region;
    logic        in_frame, is_edge, frame_end;

    // Remainder pixels beyond the last full section fold into the last column/row.
    always_comb begin
        pix_col = int'(x_count) / SEC_W;
        if (pix_col > NUM_COLS - 1) pix_col = NUM_COLS - 1;
        pix_row = int'(y_count) / SEC_H;
        if (pix_row > NUM_ROWS - 1) pix_row = NUM_ROWS - 1;
        pix_region = RW'(pix_row * NUM_COLS + pix_col);
        in_frame   = (int'(x_count) < WIDTH) && (int'(y_count) < HEIGHT);
        is_edge    = vga_ready && in_frame && (filtered_video > PIX_W'(EDGE_THRESH));
        frame_end  = vga_ready && (int'(x_count) == WIDTH - 1) && (int'(y_count) == HEIGHT - 1);
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            live_inc[i] = live[i];
            if (is_edge && (pix_region == RW'(i)) && (live[i] != CMAX))
                live_inc[i] = live[i] + COUNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                live[i]   <= '0;
                snap[i]   <= '0;
                smooth[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                live[i] <= frame_end ? '0 : live_inc[i];
                if (frame_end && (state == ACCUM))
                    snap[i] <= live_inc[i];
                if (state == SMOOTH)
                    smooth[i] <= smooth[i] - (smooth[i] >> SMOOTH_SHIFT) + (snap[i] >> SMOOTH_SHIFT);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= ACCUM;
        else       state <= state_next;
    end

    logic [RW-1:0]      scan_idx, cand, cur, decided;
    logic [COUNT_W-1:0] cand_val, scan_val, cur_val, dec_val;
    logic               take_cand;
    int                 dec_col, dec_row;

    always_comb begin
        state_next = state;
        case (state)
            ACCUM:   if (frame_end) state_next = SMOOTH;
            SMOOTH:  state_next = SCAN;
            SCAN:    if (scan_idx == RW'(N - 1)) state_next = DECIDE;
            DECIDE:  state_next = ACCUM;
            default: state_next = ACCUM;
        endcase
    end

    // Smoothed values are stable during SCAN/DECIDE, so cand_val equals smooth[cand].
    always_comb begin
        scan_val  = smooth[scan_idx];
        cur_val   = smooth[cur];
        take_cand = (cand == cur) ||
                    ({1'b0, cand_val} > ({1'b0, cur_val} + {1'b0, COUNT_W'(HYSTERESIS)}));
        decided   = take_cand ? cand : cur;
        dec_val   = take_cand ? cand_val : cur_val;
        dec_col   = int'(decided) % NUM_COLS;
        dec_row   = int'(decided) / NUM_COLS;
    end

    assign busy = (state != ACCUM);

    always_ff @(posedge clk) begin
        if (reset) begin
            scan_idx      <= '0;
            cand          <= '0;
            cand_val      <= '0;
            cur           <= '0;
            col_leds      <= NUM_COLS'(1);
            row_leds      <= NUM_ROWS'(1);
            best_region   <= '0;
            best_count    <= '0;
            result_valid  <= 1'b0;
            frame_overrun <= 1'b0;
        end else begin
            result_valid  <= 1'b0;
            frame_overrun <= frame_end && busy;
            case (state)
                SMOOTH: scan_idx <= '0;
                SCAN: begin
                    scan_idx <= scan_idx + RW'(1);
                    if ((scan_idx == '0) || (scan_val > cand_val)) begin
                        cand     <= scan_idx;
                        cand_val <= scan_val;
                    end
                end
                DECIDE: begin
                    cur          <= decided;
                    best_region  <= decided;
                    best_count   <= dec_val;
                    col_leds     <= NUM_COLS'(1) << dec_col;
                    row_leds     <= NUM_ROWS'(1) << dec_row;
                    result_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/edge_region_tracker.md
Name: edge_region_tracker

Overview:
Successor to the per-column edge density detector. It counts thresholded edge pixels from the Sobel stream in a NUM_COLS x NUM_ROWS grid of regions, snapshots the counts at frame end, and smooths them with an EMA. A multi-cycle FSM then scans for the densest region and applies hysteresis. It drives one-hot column/row LEDs plus the winning index, and sits after the Sobel filter beside the VGA timing counters.

Parameters:
WIDTH, 640, active pixels per line
HEIGHT, 480, active lines per frame
NUM_COLS, 18, region columns (1..32)
NUM_ROWS, 2, region rows (1..8)
PIX_W, 12, filtered_video width
COUNT_W, 16, region counter width (saturating)
EDGE_THRESH, 0, pixel counts as edge iff filtered_video > EDGE_THRESH
SMOOTH_SHIFT, 1, EMA shift K (0 = no smoothing)
HYSTERESIS, 60, margin (COUNT_W bits) needed to switch region

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
vga_ready  in  1  pixel-valid strobe; all counting/frame detection qualified by it
filtered_video  in  PIX_W  edge magnitude for current pixel
x_count  in  10  pixel column
y_count  in  9  pixel row
col_leds  out  NUM_COLS  one-hot winning column
row_leds  out  NUM_ROWS  one-hot winning row
best_region  out  RW=$clog2(NUM_COLS*NUM_ROWS) (min 1)  winning region index = row*NUM_COLS+col
best_count  out  COUNT_W  smoothed count of winning region
result_valid  out  1  one-cycle pulse when outputs update
busy  out  1  high while FSM not in ACCUM
frame_overrun  out  1  one-cycle pulse when frame end arrives while busy

Behaviour:
- Region mapping: SEC_W=WIDTH/NUM_COLS, SEC_H=HEIGHT/NUM_ROWS; col=min(x/SEC_W,NUM_COLS-1), row=min(y/SEC_H,NUM_ROWS-1). Remainder pixels fold into the last column/row. Pixels with x>=WIDTH or y>=HEIGHT are ignored.
- Live counters: on vga_ready with an edge pixel, increment that region's counter. Counters saturate at 2^COUNT_W-1, no wrap.
- Frame end is vga_ready with x==WIDTH-1 and y==HEIGHT-1 (cycle T):
  - In ACCUM: the snapshot captures all live counts, including this pixel's increment. All live counters clear the same cycle. The next pixel (0,0) counts normally.
  - When busy: no snapshot is taken, frame_overrun pulses, and live counters still clear.
- FSM, ACCUM -> SMOOTH -> SCAN -> DECIDE -> ACCUM:
  - SMOOTH (T+1): all regions updated in parallel, s <= s - (s>>K) + (c>>K). The result never exceeds the counter max.
  - SCAN (T+2 .. T+1+N, N=NUM_COLS*NUM_ROWS): one region compared per cycle in ascending index order. A region replaces the candidate only on strict >, so ties go to the lowest index. The candidate is initialised to region 0.
  - DECIDE (T+2+N): switch current region to candidate iff candidate==current, or s[cand] > s[cur]+HYSTERESIS. The comparison is done at COUNT_W+1 bits, with no overflow.
- Output registers load at the DECIDE edge from the newly decided region, never the prior one. col_leds, row_leds, best_region and best_count update together, and result_valid is high during cycle T+3+N only.
- Counting continues uninterrupted while busy.
- vga_ready low: no counting, no frame detection, but the FSM still advances every clk.
- Reset, including mid-SMOOTH/SCAN:
  - Clears live, snapshot and smoothed counters; FSM returns to ACCUM; current region becomes 0.
  - Outputs: col_leds=1, row_leds=1, best_region=0, best_count=0, result_valid=0, busy=0, frame_overrun=0.

Test Plan:
(Config unless noted: WIDTH=16, HEIGHT=8, NUM_COLS=4, NUM_ROWS=2, SMOOTH_SHIFT=0, HYSTERESIS=4, COUNT_W=16.)
1. Reset, then frame of all-zero pixels -> result_valid pulse 11 cycles after frame-end pixel; col_leds=4'b0001, row_leds=2'b01, best_region=0, best_count=0.
2. 10 edge pixels at x=8..11, y=4..6, with others 0 -> best_region=6, col_leds=4'b0100, row_leds=2'b10, best_count=10.
3. Hysteresis, following case 2:
   - Frame with region6=10, region1=13 -> stays 6.
   - Next frame with region6=10, region1=15 -> best_region=1, best_count=15.
4. Tie from reset: regions 3 and 5 both 9 -> best_region=3. Separately, with SMOOTH_SHIFT=1 and two frames of region 2 = 20, smoothed = 10 then 15.
5. Boundaries with WIDTH=18, COUNT_W=4:
   - Edges at x=16,17 land in column 3.
   - 20 edges in one region -> best_count=15.
   - EDGE_THRESH=12'h100: 0x100 not counted, 0x101 counted.
   - Edge pixels with vga_ready=0 not counted.
6. Overrun and reset:
   - Frame end asserted again 3 cycles after a snapshot -> frame_overrun pulse; prior result still delivered on schedule.
   - reset asserted during SCAN -> next cycle busy=0 and all outputs at reset values; no result_valid for the aborted scan.
